// File: rtl/rgb_code_writer.sv
// rtl/rgb_code_writer.sv - quantize streamed RGB pixels to 3-bit codes and write them to the frame buffer
//
// Accepts 24-bit pixels over a valid/ready handshake. Each channel becomes
// one code bit (channel >= THRESH). The code is written to a raster address
// that the block generates itself. in_sof restarts the frame at address 0.
//
// Ports:
//   clk, rst_n   clock, asynchronous active-low reset
//   in_valid     pixel present on in_rgb
//   in_ready     pixel can be accepted this cycle (combinational)
//   in_rgb       {R, G, B}, 8 bits each
//   in_sof       in_rgb is the first pixel of a frame
//   mem_busy     frame buffer cannot take the pending write this cycle
//   we           write request to the frame buffer
//   waddr        write address
//   wdata        write data (colour code)
//   frame_done   one-cycle pulse after the write to the last address completes
//   sync_err     sticky: in_sof was seen mid-frame
//   clr_err      synchronous clear of sync_err
module rgb_code_writer #(
    parameter int          H_PIXELS = 640,
    parameter int          V_PIXELS = 480,
    parameter int          ADDR_W   = 19,
    parameter logic [7:0]  THRESH   = 8'h11
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [23:0]       in_rgb,
    input  logic              in_sof,
    input  logic              mem_busy,
    output logic              we,
    output logic [ADDR_W-1:0] waddr,
    output logic [2:0]        wdata,
    output logic              frame_done,
    output logic              sync_err,
    input  logic              clr_err
);

    localparam int                LAST_INT = H_PIXELS * V_PIXELS - 1;
    localparam logic [ADDR_W-1:0] LAST     = ADDR_W'(LAST_INT);

    logic              we_q,         we_d;
    logic [ADDR_W-1:0] waddr_q,      waddr_d;
    logic [2:0]        wdata_q,      wdata_d;
    logic [ADDR_W-1:0] addr_cnt_q,   addr_cnt_d;
    logic              frame_done_q, frame_done_d;
    logic              sync_err_q,   sync_err_d;

    logic              accept;
    logic              complete;
    logic [ADDR_W-1:0] used_addr;
    logic [2:0]        code;

    // A stalled write blocks new input; there is no skid buffer.
    assign in_ready  = !(we_q && mem_busy);
    assign accept    = in_valid && in_ready;
    assign complete  = we_q && !mem_busy;
    assign used_addr = in_sof ? '0 : addr_cnt_q;

    assign code = {in_rgb[23:16] >= THRESH,
                   in_rgb[15:8]  >= THRESH,
                   in_rgb[7:0]   >= THRESH};

    always_comb begin
        we_d         = we_q;
        waddr_d      = waddr_q;
        wdata_d      = wdata_q;
        addr_cnt_d   = addr_cnt_q;
        frame_done_d = complete && (waddr_q == LAST);
        sync_err_d   = sync_err_q;

        if (accept) begin
            // Also covers reload on the completion edge of the previous write.
            we_d       = 1'b1;
            waddr_d    = used_addr;
            wdata_d    = code;
            addr_cnt_d = (used_addr == LAST) ? '0 : used_addr + ADDR_W'(1);
        end else if (complete) begin
            we_d = 1'b0;
        end

        // Set has priority over clear.
        if (accept && in_sof && (addr_cnt_q != '0)) begin
            sync_err_d = 1'b1;
        end else if (clr_err) begin
            sync_err_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            we_q         <= 1'b0;
            waddr_q      <= '0;
            wdata_q      <= '0;
            addr_cnt_q   <= '0;
            frame_done_q <= 1'b0;
            sync_err_q   <= 1'b0;
        end else begin
            we_q         <= we_d;
            waddr_q      <= waddr_d;
            wdata_q      <= wdata_d;
            addr_cnt_q   <= addr_cnt_d;
            frame_done_q <= frame_done_d;
            sync_err_q   <= sync_err_d;
        end
    end

    assign we         = we_q;
    assign waddr      = waddr_q;
    assign wdata      = wdata_q;
    assign frame_done = frame_done_q;
    assign sync_err   = sync_err_q;

endmodule
